keypad_entry: RTL and testbench

KEYPAD_ENTRY -- requirements
Module: keypad_entry

---
 rtl/keypad_entry.sv | 139 +++++++++++++
 tb/tb_keypad_entry.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner: column scan, per-key debounce, one pulse per press,
// and a four-digit shift register of the most recent hex keys.
module keypad_entry #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] hex_num_4digit
);

  localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE    = CNT_W'(3);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       col, col_nxt;
  logic [1:0]       cand_row, cand_row_nxt;
  logic [CNT_W-1:0] scan_cnt, scan_cnt_nxt;
  logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
  logic [3:0]       row_p0, row_p1;
  logic             load_key;
  logic [3:0]       new_code;

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  assign new_code  = key_map(cand_row, col);
  assign col_out   = ~(4'b0001 << col);
  assign key_valid = (state == ACCEPT);

  // The first SETTLE cycles of a column still see rows sensed under the previous
  // column because of the synchronizer, so presses are ignored until then.
  always_comb begin
    state_nxt    = state;
    col_nxt      = col;
    cand_row_nxt = cand_row;
    scan_cnt_nxt = scan_cnt;
    deb_cnt_nxt  = deb_cnt;
    load_key     = 1'b0;
    case (state)
      SCAN: begin
        if (row_p1 != 4'hF && scan_cnt >= SETTLE) begin
          state_nxt    = DEBOUNCE;
          cand_row_nxt = lowest_low(row_p1);
          deb_cnt_nxt  = '0;
        end else if (scan_cnt == SCAN_LAST) begin
          col_nxt      = col + 2'd1;
          scan_cnt_nxt = '0;
        end else begin
          scan_cnt_nxt = scan_cnt + ONE;
        end
      end
      DEBOUNCE: begin
        if (!row_p1[cand_row]) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt = ACCEPT;
            load_key  = 1'b1;
          end else begin
            deb_cnt_nxt = deb_cnt + ONE;
          end
        end else begin
          state_nxt    = SCAN;
          col_nxt      = col + 2'd1;
          scan_cnt_nxt = '0;
          deb_cnt_nxt  = '0;
        end
      end
      ACCEPT: begin
        state_nxt   = RELEASE;
        deb_cnt_nxt = '0;
      end
      default: begin
        if (row_p1 == 4'hF) begin
          if (deb_cnt == DEB_LAST) begin
            state_nxt    = SCAN;
            col_nxt      = col + 2'd1;
            scan_cnt_nxt = '0;
            deb_cnt_nxt  = '0;
          end else begin
            deb_cnt_nxt = deb_cnt + ONE;
          end
        end else begin
          deb_cnt_nxt = '0;
        end
      end
    endcase
  end

  // Code and digit history load on entry to ACCEPT so they are valid with the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN;
      col            <= 2'd0;
      cand_row       <= 2'd0;
      scan_cnt       <= '0;
      deb_cnt        <= '0;
      row_p0         <= 4'hF;
      row_p1         <= 4'hF;
      key_code       <= 4'h0;
      hex_num_4digit <= 16'h0000;
    end else begin
      state    <= state_nxt;
      col      <= col_nxt;
      cand_row <= cand_row_nxt;
      scan_cnt <= scan_cnt_nxt;
      deb_cnt  <= deb_cnt_nxt;
      row_p0   <= row_in;
      row_p1   <= row_p0;
      if (load_key) begin
        key_code       <= new_code;
        hex_num_4digit <= {hex_num_4digit[11:0], new_code};
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a behavioural keypad matrix model.
module tb_keypad_entry;

  localparam int SCAN_CYCLES     = 8;
  localparam int DEBOUNCE_CYCLES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] hex_num_4digit;

  logic       pressed = 1'b0, pressed2 = 1'b0;
  logic [1:0] pr = 2'd0, pc = 2'd0, pr2 = 2'd0, pc2 = 2'd0;

  int         checks = 0;
  int         errors = 0;
  int         pulses = 0;
  logic [3:0] last_code = 4'h0;

  typedef struct {
    logic [1:0]  r, c, r2, c2;
    logic        dual;
    int          hold;
    logic [3:0]  code;
    logic [15:0] hex;
  } vec_t;

  vec_t tbl [10];

  keypad_entry #(.SCAN_CYCLES(SCAN_CYCLES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .key_valid(key_valid), .key_code(key_code), .hex_num_4digit(hex_num_4digit)
  );

  always #5 clk = ~clk;

  // A closed switch pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    if (pressed && !col_out[pc]) row_in[pr] = 1'b0;
    if (pressed2 && !col_out[pc2]) row_in[pr2] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulses    <= pulses + 1;
      last_code <= key_code;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c, input int hold);
    pr = r;
    pc = c;
    pressed = 1'b1;
    repeat (hold) tick();
    pressed  = 1'b0;
    pressed2 = 1'b0;
    repeat (40) tick();
  endtask

  initial begin
    int         p0;
    logic [3:0] exp_col;
    logic [3:0] prev;
    logic       found;

    tbl[0] = '{2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 80,  4'h1, 16'h0001};
    tbl[1] = '{2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 80,  4'h2, 16'h0012};
    tbl[2] = '{2'd0, 2'd2, 2'd0, 2'd0, 1'b0, 80,  4'h3, 16'h0123};
    tbl[3] = '{2'd0, 2'd3, 2'd0, 2'd0, 1'b0, 80,  4'hA, 16'h123A};
    tbl[4] = '{2'd3, 2'd1, 2'd0, 2'd0, 1'b0, 80,  4'h0, 16'h23A0};
    tbl[5] = '{2'd2, 2'd1, 2'd1, 2'd1, 1'b1, 80,  4'h5, 16'h3A05};
    tbl[6] = '{2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 500, 4'hE, 16'hA05E};
    tbl[7] = '{2'd3, 2'd2, 2'd0, 2'd0, 1'b0, 80,  4'hF, 16'h05EF};
    tbl[8] = '{2'd3, 2'd3, 2'd0, 2'd0, 1'b0, 80,  4'hD, 16'h5EFD};
    tbl[9] = '{2'd1, 2'd3, 2'd0, 2'd0, 1'b0, 80,  4'hB, 16'hEFDB};

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    check("reset_col_out", col_out, 4'b1110);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_key_code", key_code, 4'h0);
    check("reset_hex", hex_num_4digit, 16'h0000);
    rst = 1'b0;

    // Idle scanning
    for (int i = 0; i < 100; i++) begin
      exp_col = ~(4'b0001 << ((i / SCAN_CYCLES) % 4));
      check("idle_col_out", col_out, exp_col);
      check("idle_key_valid", key_valid, 1'b0);
      tick();
    end
    check("idle_hex", hex_num_4digit, 16'h0000);
    check("idle_pulses", pulses, 0);

    // Clean 40-cycle press of row1/col2 straight out of reset
    do_reset();
    p0 = pulses;
    press(2'd1, 2'd2, 40);
    check("key6_pulses", pulses - p0, 1);
    check("key6_code", last_code, 4'h6);
    check("key6_key_code", key_code, 4'h6);
    check("key6_hex", hex_num_4digit, 16'h0006);

    // Bounce during debounce: low 10, high 1, low 10
    do_reset();
    p0 = pulses;
    pr = 2'd0;
    pc = 2'd0;
    pressed = 1'b1;
    repeat (10) tick();
    pressed = 1'b0;
    tick();
    pressed = 1'b1;
    tick();
    check("bounce_col_frozen", col_out, 4'b1110);
    tick();
    check("bounce_resume_next_col", col_out, 4'b1101);
    repeat (7) tick();
    check("bounce_scan_restart", col_out, 4'b1101);
    tick();
    pressed = 1'b0;
    repeat (40) tick();
    check("bounce_no_pulse", pulses - p0, 0);
    press(2'd0, 2'd0, 80);
    check("bounce_then_stable_pulses", pulses - p0, 1);
    check("bounce_then_stable_code", last_code, 4'h1);
    check("bounce_then_stable_hex", hex_num_4digit, 16'h0001);

    // Key sequence table
    do_reset();
    for (int i = 0; i < 10; i++) begin
      p0 = pulses;
      pr2 = tbl[i].r2;
      pc2 = tbl[i].c2;
      pressed2 = tbl[i].dual;
      press(tbl[i].r, tbl[i].c, tbl[i].hold);
      check($sformatf("tbl%0d_pulses", i), pulses - p0, 1);
      check($sformatf("tbl%0d_code", i), last_code, tbl[i].code);
      check($sformatf("tbl%0d_hex", i), hex_num_4digit, tbl[i].hex);
    end

    // Chatter while waiting for release must not retrigger
    p0 = pulses;
    pr = 2'd2;
    pc = 2'd1;
    pressed = 1'b1;
    repeat (80) tick();
    for (int k = 0; k < 2; k++) begin
      pressed = 1'b0;
      repeat (6) tick();
      pressed = 1'b1;
      repeat (6) tick();
    end
    pressed = 1'b0;
    repeat (40) tick();
    check("release_chatter_pulses", pulses - p0, 1);
    check("release_chatter_code", last_code, 4'h8);
    check("release_chatter_hex", hex_num_4digit, 16'hFDB8);

    // Reset in the middle of debounce
    do_reset();
    press(2'd0, 2'd0, 80);
    press(2'd0, 2'd1, 80);
    press(2'd0, 2'd2, 80);
    press(2'd1, 2'd0, 80);
    check("abort_setup_hex", hex_num_4digit, 16'h1234);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      prev = col_out;
      tick();
      if (prev == 4'b0111 && col_out == 4'b1110) found = 1'b1;
    end
    check("abort_sync_col0", found, 1'b1);
    if (found) begin
      p0 = pulses;
      pr = 2'd0;
      pc = 2'd0;
      pressed = 1'b1;
      repeat (12) tick();
      check("abort_debounce_frozen", col_out, 4'b1110);
      rst = 1'b1;
      tick();
      check("abort_hex", hex_num_4digit, 16'h0000);
      check("abort_key_valid", key_valid, 1'b0);
      check("abort_col_out", col_out, 4'b1110);
      check("abort_key_code", key_code, 4'h0);
      rst = 1'b0;
      pressed = 1'b0;
      repeat (40) tick();
      check("abort_no_pulse", pulses - p0, 0);
      check("abort_hex_after", hex_num_4digit, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
